// File: rtl/nram_pkg.sv
// Shared definitions for the NRAM arbiter: FSM state encoding and the
// default storage geometry / burst limit used by the arbiter and its bus.
package nram_pkg;

  localparam int NRAM_DATA_W    = 8;
  localparam int NRAM_ADDR_W    = 6;
  localparam int NRAM_MAX_BURST = 4;
  localparam int BURST_W        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/nram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the NRAMMUX storage.
// The slave side is the arbiter; the master side is the requesters plus the
// RAM model that returns io_ram_Q.
interface nram_arbiter_if
  import nram_pkg::*;
#(
  parameter int DATA_W = NRAM_DATA_W,
  parameter int ADDR_W = NRAM_ADDR_W
);

  logic [1:0]        io_req;
  logic [1:0]        io_we;
  logic [ADDR_W-1:0] io_addr0;
  logic [ADDR_W-1:0] io_addr1;
  logic [DATA_W-1:0] io_wdata0;
  logic [DATA_W-1:0] io_wdata1;
  logic [1:0]        io_gnt;
  logic [1:0]        io_rvalid;
  logic [DATA_W-1:0] io_rdata;
  logic [DATA_W-1:0] io_ram_D;
  logic [ADDR_W-1:0] io_ram_WADD;
  logic [ADDR_W-1:0] io_ram_RADD;
  logic              io_ram_WE;
  logic [DATA_W-1:0] io_ram_Q;

  modport master (
    output io_req, io_we, io_addr0, io_addr1, io_wdata0, io_wdata1, io_ram_Q,
    input  io_gnt, io_rvalid, io_rdata, io_ram_D, io_ram_WADD, io_ram_RADD, io_ram_WE
  );

  modport slave (
    input  io_req, io_we, io_addr0, io_addr1, io_wdata0, io_wdata1, io_ram_Q,
    output io_gnt, io_rvalid, io_rdata, io_ram_D, io_ram_WADD, io_ram_RADD, io_ram_WE
  );

endinterface

// File: rtl/nram_rr_pick.sv
// Two-way round-robin chooser: with a single request that requester wins,
// with both requesting the one that did not own the RAM last wins.
module nram_rr_pick (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] choice
);

  // one-hot choice from the request pair and the previous owner
  always_comb begin
    choice = 2'b00;
    case (req)
      2'b01:   choice = 2'b01;
      2'b10:   choice = 2'b10;
      2'b11:   choice = last_owner ? 2'b01 : 2'b10;
      default: choice = 2'b00;
    endcase
  end

endmodule

// File: rtl/nram_arbiter.sv
// Two-requester arbiter for the shared NRAMMUX storage. Grants are
// combinational from the FSM state and the requests; a burst counter limits
// how long one owner can hold the RAM while the other waits. Reads return
// one cycle after the grant, aligned with the RAM's registered output.
// Optional build macro NRAM_ARB_STATS_EN adds saturating per-requester
// grant counters io_gcnt0 / io_gcnt1.
module nram_arbiter
  import nram_pkg::*;
#(
  parameter int DATA_W    = NRAM_DATA_W,
  parameter int ADDR_W    = NRAM_ADDR_W,
  parameter int MAX_BURST = NRAM_MAX_BURST
) (
  input logic           clk,
  input logic           reset,
  nram_arbiter_if.slave bus
`ifdef NRAM_ARB_STATS_EN
  ,
  output logic [15:0]   io_gcnt0,
  output logic [15:0]   io_gcnt1
`endif
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  arb_state_e         state, state_nxt;
  logic [BURST_W-1:0] burst_cnt, burst_nxt;
  logic               last_owner, last_nxt;
  logic [1:0]         pick;
  logic [1:0]         gnt;
  logic               cur, oth;

  logic               own_idx;
  logic               wr_fire, rd_fire;
  logic [ADDR_W-1:0]  own_addr;
  logic [DATA_W-1:0]  own_wdata;
  logic [ADDR_W-1:0]  wadd_p0, radd_p0;
  logic [DATA_W-1:0]  wd_p0;
  logic [1:0]         rvld_p1;

  nram_rr_pick u_pick (
    .req        (bus.io_req),
    .last_owner (last_owner),
    .choice     (pick)
  );

  assign cur = (state == OWN1);
  assign oth = ~cur;

  // state, burst counter and last owner registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_nxt;
      last_owner <= last_nxt;
    end
  end

  // grant decision and next-state; grant is forced low while in reset
  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    last_nxt  = last_owner;
    gnt       = 2'b00;
    case (state)
      IDLE: begin
        if (pick != 2'b00) begin
          gnt       = pick;
          state_nxt = pick[1] ? OWN1 : OWN0;
          burst_nxt = BURST_W'(1);
          last_nxt  = pick[1];
        end
      end
      OWN0, OWN1: begin
        if (bus.io_req[cur] && !(burst_cnt == BURST_MAX && bus.io_req[oth])) begin
          gnt[cur] = 1'b1;
          if (burst_cnt < BURST_MAX) burst_nxt = burst_cnt + 1'b1;
        end else if (bus.io_req[oth]) begin
          gnt[oth]  = 1'b1;
          state_nxt = oth ? OWN1 : OWN0;
          burst_nxt = BURST_W'(1);
          last_nxt  = oth;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!reset) gnt = 2'b00;
  end

  assign own_idx   = gnt[1];
  assign own_addr  = own_idx ? bus.io_addr1 : bus.io_addr0;
  assign own_wdata = own_idx ? bus.io_wdata1 : bus.io_wdata0;
  assign wr_fire   = (gnt != 2'b00) && bus.io_we[own_idx];
  assign rd_fire   = (gnt != 2'b00) && !bus.io_we[own_idx];

  assign bus.io_gnt      = gnt;
  assign bus.io_ram_WE   = wr_fire;
  assign bus.io_ram_WADD = wr_fire ? own_addr  : wadd_p0;
  assign bus.io_ram_D    = wr_fire ? own_wdata : wd_p0;
  assign bus.io_ram_RADD = rd_fire ? own_addr  : radd_p0;

  // ---- stage p0 -> p1: hold last RAM addresses/data, launch read-valid ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wadd_p0 <= '0;
      wd_p0   <= '0;
      radd_p0 <= '0;
      rvld_p1 <= 2'b00;
    end else begin
      if (wr_fire) begin
        wadd_p0 <= own_addr;
        wd_p0   <= own_wdata;
      end
      if (rd_fire) radd_p0 <= own_addr;
      rvld_p1 <= rd_fire ? gnt : 2'b00;
    end
  end

  assign bus.io_rvalid = rvld_p1;
  assign bus.io_rdata  = (rvld_p1 != 2'b00) ? bus.io_ram_Q : '0;

`ifdef NRAM_ARB_STATS_EN
  // saturating grant counters per requester
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_gcnt0 <= '0;
      io_gcnt1 <= '0;
    end else begin
      if (gnt[0] && io_gcnt0 != 16'hFFFF) io_gcnt0 <= io_gcnt0 + 16'd1;
      if (gnt[1] && io_gcnt1 != 16'hFFFF) io_gcnt1 <= io_gcnt1 + 16'd1;
    end
  end
`endif

endmodule
